// File: rtl/alu_result_fifo.sv
// Ordered DEPTH-entry buffer for {result, zero, opcode} between the ALU and its consumer.
// Optional pop statistics are enabled by defining ALU_RESULT_STATS_EN.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic [1:0]               in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_zero,
  output logic [1:0]               out_opcode,
`ifdef ALU_RESULT_STATS_EN
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_total,
  output logic [CNT_W-1:0]         stat_zero,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 3;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_fifo: DEPTH must be a power of two >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_result_fifo: CNT_W must be >= 1");
  end

  // One word per entry keeps the three fields of an entry together.
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);

  // in_ready depends only on registered state and is held low while in reset.
  assign in_ready  = ~rst & ~full;
  assign out_valid = ~empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign head = mem[rd_ptr_reg];
  assign {out_result, out_zero, out_opcode} = out_valid ? head : '0;
  assign level = level_reg;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_result, in_zero, in_opcode};
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
    end
  end

`ifdef ALU_RESULT_STATS_EN
  logic [CNT_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0] zero_reg, zero_next;

  // Saturating pop counters; a clear overrides any same-cycle pop.
  always_comb begin
    total_next = total_reg;
    zero_next  = zero_reg;
    if (stat_clr) begin
      total_next = '0;
      zero_next  = '0;
    end else if (pop) begin
      if (total_reg != '1) begin
        total_next = total_reg + CNT_W'(1);
      end
      if (out_zero && zero_reg != '1) begin
        zero_next = zero_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_reg <= '0;
      zero_reg  <= '0;
    end else begin
      total_reg <= total_next;
      zero_reg  <= zero_next;
    end
  end

  assign stat_total = total_reg;
  assign stat_zero  = zero_reg;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table for fill/drain plus hand-written multi-cycle sequences.
module tb_alu_result_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DATA_W-1:0] in_result;
  logic             in_zero;
  logic [1:0]       in_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [DATA_W-1:0] out_result;
  logic             out_zero;
  logic [1:0]       out_opcode;
  logic [2:0]       level;
`ifdef ALU_RESULT_STATS_EN
  logic             stat_clr;
  logic [CNT_W-1:0] stat_total;
  logic [CNT_W-1:0] stat_zero;
`endif

  int vectors;
  int miscompares;

  alu_result_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zero   (in_zero),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_opcode(out_opcode),
`ifdef ALU_RESULT_STATS_EN
    .stat_clr  (stat_clr),
    .stat_total(stat_total),
    .stat_zero (stat_zero),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       z;
    logic [1:0] op;
    logic       ordy;
    logic       e_ov;
    logic       e_ir;
    logic [2:0] e_lvl;
    logic [7:0] e_res;
    logic       e_z;
    logic [1:0] e_op;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then let outputs settle.
  task automatic step(input logic iv, input logic [7:0] d, input logic z,
                      input logic [1:0] op, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_result = d;
    in_zero   = z;
    in_opcode = op;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_head(input string tag, input logic [2:0] lvl,
                            input logic [7:0] res, input logic z, input logic [1:0] op);
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".level"}, level, lvl);
    check({tag, ".out_result"}, out_result, res);
    check({tag, ".out_zero"}, out_zero, z);
    check({tag, ".out_opcode"}, out_opcode, op);
    $display("%s: level=%0d head=%02h z=%0b op=%0d", tag, level, out_result, out_zero, out_opcode);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_zero   = 1'b0;
    in_opcode = '0;
    out_ready = 1'b0;
`ifdef ALU_RESULT_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Fill to full, refuse a fifth offer, then drain in order.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 8'h55, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd4, 8'h11, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd4, 8'h11, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h22, 1'b0, 2'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h33, 1'b1, 2'd2};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h44, 1'b0, 2'd3};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 2'd0};

    // Reset state
    #12;
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.level", level, 3'd0);
    check("rst.out_result", out_result, 8'h00);
`ifdef ALU_RESULT_STATS_EN
    check("rst.stat_total", stat_total, 4'd0);
    check("rst.stat_zero", stat_zero, 4'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release.in_ready", in_ready, 1'b1);
    $display("reset: in_ready=%0b out_valid=%0b level=%0d", in_ready, out_valid, level);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].z, vecs[i].op, vecs[i].ordy);
      check($sformatf("tbl[%0d].out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("tbl[%0d].in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("tbl[%0d].level", i), level, vecs[i].e_lvl);
      check($sformatf("tbl[%0d].out_result", i), out_result, vecs[i].e_res);
      check($sformatf("tbl[%0d].out_zero", i), out_zero, vecs[i].e_z);
      check($sformatf("tbl[%0d].out_opcode", i), out_opcode, vecs[i].e_op);
      $display("tbl[%0d]: iv=%0b d=%02h ordy=%0b -> ov=%0b ir=%0b level=%0d head=%02h",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, out_valid, in_ready, level, out_result);
    end

    // Simultaneous push/pop at level 2 for 10 cycles; pointers wrap several times.
    step(1'b1, 8'hA0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 2'd1, 1'b0);
    check("pp.prefill_level", level, 3'd1);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] nd;
      logic [7:0] hd;
      nd = 8'hA2 + 8'(k);
      hd = 8'hA0 + 8'(k);
      step(1'b1, nd, nd[0], nd[1:0], 1'b1);
      check_head($sformatf("pp[%0d]", k), 3'd2, hd, hd[0], hd[1:0]);
    end
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    check_head("pp.drain0", 3'd2, 8'hAA, 1'b0, 2'd2);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    check_head("pp.drain1", 3'd1, 8'hAB, 1'b1, 2'd3);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("pp.empty_valid", out_valid, 1'b0);

    // Head stability under back-pressure, with a second entry arriving behind it.
    step(1'b1, 8'h00, 1'b1, 2'd1, 1'b0);
    check("hold.no_bypass", out_valid, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 2'd2, 1'b0);
    check_head("hold[0]", 3'd1, 8'h00, 1'b1, 2'd1);
    for (int c = 1; c < 5; c++) begin
      step(1'b0, 8'hFF, 1'b0, 2'd3, 1'b0);
      check_head($sformatf("hold[%0d]", c), 3'd2, 8'h00, 1'b1, 2'd1);
    end
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    check_head("hold.pop0", 3'd2, 8'h00, 1'b1, 2'd1);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    check_head("hold.pop1", 3'd1, 8'hAB, 1'b0, 2'd2);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("hold.empty_valid", out_valid, 1'b0);

    // Asynchronous reset mid-traffic at level 3.
    step(1'b1, 8'hC1, 1'b0, 2'd1, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 2'd2, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 2'd3, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("arst.pre_level", level, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.level", level, 3'd0);
    check("arst.in_ready", in_ready, 1'b0);
    check("arst.out_result", out_result, 8'h00);
    $display("arst: out_valid=%0b level=%0d in_ready=%0b", out_valid, level, in_ready);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst.release_in_ready", in_ready, 1'b1);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    check("arst.post_level", level, 3'd0);
    check("arst.post_out_valid", out_valid, 1'b0);

`ifdef ALU_RESULT_STATS_EN
    // Clear accumulated counts, then 20 pops with 7 zero flags.
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("stat.clr_total", stat_total, 4'd0);
    check("stat.clr_zero", stat_zero, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), (i < 7), 2'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("stat.total_sat", stat_total, 4'd15);
    check("stat.zero", stat_zero, 4'd7);
    $display("stats: total=%0d zero=%0d", stat_total, stat_zero);
    step(1'b1, 8'h00, 1'b1, 2'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("stat.clr_pop_total", stat_total, 4'd0);
    check("stat.clr_pop_zero", stat_zero, 4'd0);
    check("stat.clr_pop_level", level, 3'd0);
    $display("stats clr+pop: total=%0d zero=%0d", stat_total, stat_zero);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
